// File: rtl/run_monitor_pkg.sv
// Shared types and constants for the run_monitor retirement-stream watchdog.
package run_monitor_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [1:0]  EXIT_NONE       = 2'd0;
  localparam logic [1:0]  EXIT_ECALL      = 2'd1;
  localparam logic [1:0]  EXIT_SP         = 2'd2;
  localparam logic [1:0]  EXIT_TIMEOUT    = 2'd3;
  localparam logic [6:0]  OPC_ECALL       = 7'h73;
  localparam logic [31:0] PC_INIT_DEFAULT = 32'h0100_0000;

endpackage

// File: rtl/run_monitor_trace_ring.sv
// Ring buffer of the most recent retired PCs; index 0 reads the newest entry.
module trace_ring
  import run_monitor_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wr_en_i,
  input  logic [XLEN-1:0] wr_pc_i,
  input  logic [AW-1:0]   rd_idx_i,
  output logic [XLEN-1:0] rd_pc_o,
  output logic [AW:0]     count_o
);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW:0]     count_q;
  logic [AW-1:0]   rd_addr;

  // Storage carries no reset so it can map onto RAM; unwritten slots are masked by count_q.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_pc_i;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (wr_en_i) begin
      wr_ptr_q <= wr_ptr_q + 1'b1;
      if (count_q != (AW+1)'(DEPTH)) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign rd_addr = wr_ptr_q - AW'(1) - rd_idx_i;
  assign rd_pc_o = ({1'b0, rd_idx_i} < count_q) ? mem_q[rd_addr] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/run_monitor.sv
// Run-control monitor: ECALL / SP-return / timeout detection, drain, then done + cause.
// Optional PC trace buffer is built when RUN_MONITOR_TRACE_EN is defined.
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] PC_INIT      = PC_INIT_DEFAULT,
  parameter logic [XLEN-1:0] MEM_DEPTH    = 32'h0010_0000,
  parameter int              MAX_CYCLES   = 100000,
  parameter int              DRAIN_CYCLES = 3,
  parameter int              TRACE_DEPTH  = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         ret_valid,
  input  logic [XLEN-1:0]              ret_pc,
  input  logic [6:0]                   ret_opcode,
  input  logic [XLEN-1:0]              sp_value,
  output logic                         done,
  output logic [1:0]                   exit_cause,
  output logic [31:0]                  cycle_count,
  output logic [31:0]                  retire_count,
  output logic                         stack_used,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx,
  output logic [XLEN-1:0]              trace_rd_pc,
  output logic [$clog2(TRACE_DEPTH):0] trace_count
);

  localparam logic [XLEN-1:0] SP_TOP = PC_INIT + MEM_DEPTH;
  localparam int              DW     = $clog2(DRAIN_CYCLES + 2);

  state_e        state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [1:0]    cause_q, cause_d;
  logic          done_q;
  logic          stack_used_q;
  logic [31:0]   cycle_q, retire_q;

  logic active, in_run, hit_ecall, hit_sp, hit_tmo, fire_tmo;

  assign active    = (state_q != ST_DONE);
  assign in_run    = (state_q == ST_RUN);
  assign hit_ecall = ret_valid && (ret_opcode == OPC_ECALL);
  // Uses the registered flag, so a drop and return within one sample cannot trigger.
  assign hit_sp    = stack_used_q && (sp_value == SP_TOP);
  assign hit_tmo   = (cycle_q == 32'(MAX_CYCLES - 1));
  assign fire_tmo  = in_run && hit_tmo && !hit_ecall && !hit_sp;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    cause_d = cause_q;
    unique case (state_q)
      ST_RUN: begin
        if (hit_ecall || hit_sp) begin
          cause_d = hit_ecall ? EXIT_ECALL : EXIT_SP;
          if (DRAIN_CYCLES == 0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRAIN;
            drain_d = DW'(DRAIN_CYCLES);
          end
        end else if (hit_tmo) begin
          cause_d = EXIT_TIMEOUT;
          state_d = ST_DONE;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DW'(1)) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      ST_DONE: ;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      drain_q      <= '0;
      cause_q      <= EXIT_NONE;
      done_q       <= 1'b0;
      stack_used_q <= 1'b0;
      cycle_q      <= '0;
      retire_q     <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      cause_q <= cause_d;
      done_q  <= (state_d == ST_DONE);
      if (sp_value < SP_TOP) begin
        stack_used_q <= 1'b1;
      end
      // The timeout edge leaves the count at MAX_CYCLES-1 rather than stepping past it.
      if (active && !fire_tmo) begin
        cycle_q <= cycle_q + 32'd1;
      end
      if (active && ret_valid) begin
        retire_q <= retire_q + 32'd1;
      end
    end
  end

  assign done         = done_q;
  assign exit_cause   = cause_q;
  assign cycle_count  = cycle_q;
  assign retire_count = retire_q;
  assign stack_used   = stack_used_q;

`ifdef RUN_MONITOR_TRACE_EN
  trace_ring #(
    .XLEN  (XLEN),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_ring (
    .clock    (clock),
    .reset    (reset),
    .wr_en_i  (ret_valid && active),
    .wr_pc_i  (ret_pc),
    .rd_idx_i (trace_rd_idx),
    .rd_pc_o  (trace_rd_pc),
    .count_o  (trace_count)
  );
`else
  logic unused_trace_inputs;
  assign unused_trace_inputs = ^{ret_pc, trace_rd_idx};
  assign trace_rd_pc = '0;
  assign trace_count = '0;
`endif

endmodule

// File: tb/tb_run_monitor.sv
// Self-checking bench for run_monitor: table-driven ECALL run plus hand-written corner sequences.
module tb_run_monitor;

  localparam logic [31:0] TOP  = 32'h0110_0000;
  localparam logic [31:0] BASE = 32'h0100_0000;
`ifdef RUN_MONITOR_TRACE_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ret_valid = 1'b0;
  logic [31:0] ret_pc = '0;
  logic [6:0]  ret_opcode = '0;
  logic [31:0] sp_value = TOP;
  logic [1:0]  trace_rd_idx = '0;

  logic        done_a, su_a, done_b, su_b;
  logic [1:0]  cause_a, cause_b;
  logic [31:0] cyc_a, ret_a, cyc_b, ret_b, tpc_a, tpc_b;
  logic [2:0]  tcnt_a, tcnt_b;

  run_monitor #(.MAX_CYCLES(50), .DRAIN_CYCLES(3), .TRACE_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .ret_valid(ret_valid), .ret_pc(ret_pc),
    .ret_opcode(ret_opcode), .sp_value(sp_value), .done(done_a), .exit_cause(cause_a),
    .cycle_count(cyc_a), .retire_count(ret_a), .stack_used(su_a),
    .trace_rd_idx(trace_rd_idx), .trace_rd_pc(tpc_a), .trace_count(tcnt_a));

  run_monitor #(.MAX_CYCLES(1000), .DRAIN_CYCLES(0), .TRACE_DEPTH(4)) dut_nodrain (
    .clock(clock), .reset(reset), .ret_valid(ret_valid), .ret_pc(ret_pc),
    .ret_opcode(ret_opcode), .sp_value(sp_value), .done(done_b), .exit_cause(cause_b),
    .cycle_count(cyc_b), .retire_count(ret_b), .stack_used(su_b),
    .trace_rd_idx(trace_rd_idx), .trace_rd_pc(tpc_b), .trace_count(tcnt_b));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       done;
    logic [1:0] cause;
    logic       su;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic       rv;
    logic [6:0] opc;
    logic [31:0] sp;
    logic       done;
    logic [1:0] cause;
    logic       su;
    logic       done0;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic rv, input logic [6:0] opc, input logic [31:0] pc,
                      input logic [31:0] sp, input logic e_done, input logic [1:0] e_cause,
                      input logic e_su);
    exp_t e;
    ret_valid  = rv;
    ret_opcode = opc;
    ret_pc     = pc;
    sp_value   = sp;
    sb_q.push_back('{e_done, e_cause, e_su});
    @(posedge clock);
    #1;
    e = sb_q.pop_front();
    $display("t=%0t rv=%0b opc=%02h sp=%08h -> done=%0b cause=%0d su=%0b cyc=%0d ret=%0d",
             $time, rv, opc, sp, done_a, cause_a, su_a, cyc_a, ret_a);
    chk("done", {31'b0, done_a}, {31'b0, e.done});
    chk("exit_cause", {30'b0, cause_a}, {30'b0, e.cause});
    chk("stack_used", {31'b0, su_a}, {31'b0, e.su});
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    ret_valid    = 1'b0;
    ret_opcode   = '0;
    sp_value     = TOP;
    trace_rd_idx = '0;
    @(posedge clock);
    #1;
    $display("t=%0t reset -> done=%0b cause=%0d cyc=%0d ret=%0d", $time, done_a, cause_a, cyc_a, ret_a);
    chk("rst_done", {31'b0, done_a}, 32'd0);
    chk("rst_cause", {30'b0, cause_a}, 32'd0);
    chk("rst_cycle", cyc_a, 32'd0);
    chk("rst_retire", ret_a, 32'd0);
    chk("rst_su", {31'b0, su_a}, 32'd0);
    chk("rst_tcount", {29'b0, tcnt_a}, 32'd0);
    chk("rst_tpc", tpc_a, 32'd0);
    chk("rst_done0", {31'b0, done_b}, 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    // ECALL as the 10th retirement, then three drain cycles, then one frozen cycle.
    for (int k = 1; k <= 10; k++)
      tbl.push_back('{1'b1, (k == 10) ? 7'h73 : 7'h13, TOP, 1'b0,
                      (k == 10) ? 2'd1 : 2'd0, 1'b0, (k == 10)});
    tbl.push_back('{1'b0, 7'h13, TOP, 1'b0, 2'd1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 7'h13, TOP, 1'b0, 2'd1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 7'h13, TOP, 1'b1, 2'd1, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 7'h73, TOP, 1'b1, 2'd1, 1'b0, 1'b1});

    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].rv, tbl[i].opc, BASE + 32'(4 * i), tbl[i].sp, tbl[i].done, tbl[i].cause, tbl[i].su);
      chk("nodrain_done", {31'b0, done_b}, {31'b0, tbl[i].done0});
      if (i == 12) chk("ecall_retire", ret_a, 32'd10);
    end
    chk("ecall_retire_frozen", ret_a, 32'd10);
    chk("ecall_cycle_frozen", cyc_a, 32'd13);
    chk("nodrain_cause", {30'b0, cause_b}, 32'd1);

    // SP drops below the top and returns; a second ECALL during drain leaves the cause alone.
    do_reset();
    step(1'b0, 7'h13, BASE, TOP,           1'b0, 2'd0, 1'b0);
    step(1'b0, 7'h13, BASE, 32'h010F_FFF0, 1'b0, 2'd0, 1'b1);
    step(1'b0, 7'h13, BASE, TOP,           1'b0, 2'd2, 1'b1);
    chk("sp_nodrain_done", {31'b0, done_b}, 32'd1);
    chk("sp_nodrain_cause", {30'b0, cause_b}, 32'd2);
    step(1'b1, 7'h73, BASE, TOP,           1'b0, 2'd2, 1'b1);
    step(1'b0, 7'h13, BASE, TOP,           1'b0, 2'd2, 1'b1);
    step(1'b0, 7'h13, BASE, TOP,           1'b1, 2'd2, 1'b1);

    // ECALL and SP return on the same edge: ECALL wins.
    do_reset();
    step(1'b0, 7'h13, BASE, 32'h010F_FF00, 1'b0, 2'd0, 1'b1);
    step(1'b1, 7'h73, BASE, TOP,           1'b0, 2'd1, 1'b1);

    // Timeout with SP parked at the top: no SP trigger, done right after edge 50.
    do_reset();
    for (int k = 1; k <= 49; k++) step(1'b0, 7'h13, BASE, TOP, 1'b0, 2'd0, 1'b0);
    chk("tmo_cycle_pre", cyc_a, 32'd49);
    step(1'b0, 7'h13, BASE, TOP, 1'b1, 2'd3, 1'b0);
    chk("tmo_cycle", cyc_a, 32'd49);
    step(1'b1, 7'h13, BASE, TOP, 1'b1, 2'd3, 1'b0);
    chk("tmo_cycle_frozen", cyc_a, 32'd49);
    chk("tmo_retire_frozen", ret_a, 32'd0);

    // Trace ring: six retirements into a four-deep buffer.
    do_reset();
    for (int k = 0; k <= 5; k++) begin
      step(1'b1, 7'h13, BASE + 32'(4 * k), TOP, 1'b0, 2'd0, 1'b0);
      if (k == 1) begin
        trace_rd_idx = 2'd2;
        #1 chk("trace_idx_oob", tpc_a, 32'd0);
        trace_rd_idx = 2'd1;
        #1 chk("trace_idx1_early", tpc_a, TR ? BASE : 32'd0);
        trace_rd_idx = 2'd0;
      end
    end
    chk("trace_retire", ret_a, 32'd6);
    chk("trace_count", {29'b0, tcnt_a}, TR ? 32'd4 : 32'd0);
    trace_rd_idx = 2'd0;
    #1 chk("trace_idx0", tpc_a, TR ? 32'h0100_0014 : 32'd0);
    trace_rd_idx = 2'd3;
    #1 chk("trace_idx3", tpc_a, TR ? 32'h0100_0008 : 32'd0);
    trace_rd_idx = 2'd0;

    // Reset in the middle of DRAIN, then a fresh ECALL is seen normally.
    do_reset();
    step(1'b1, 7'h73, BASE, TOP, 1'b0, 2'd1, 1'b0);
    step(1'b0, 7'h13, BASE, TOP, 1'b0, 2'd1, 1'b0);
    do_reset();
    step(1'b1, 7'h73, BASE, TOP, 1'b0, 2'd1, 1'b0);
    chk("rerun_retire", ret_a, 32'd1);
    chk("rerun_cycle", cyc_a, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
